// File: rtl/stoch_stream_if.sv
// stoch_stream_if: control, LFSR-bank and result-stream signals of the stochastic stream sequencer.
// The master side is the layer controller plus datapath; the slave side is the sequencer.
interface stoch_stream_if #(
   parameter int N_LFSR = 4,
   parameter int CW     = 9
);
   logic                  START;
   logic                  ABORT;
   logic [CW-1:0]         LEN;
   logic [15:0]           SEED_IN;
   logic                  BIT_IN;
   logic                  LFSR_RST;
   logic                  LFSR_TRIG;
   logic [16*N_LFSR-1:0]  SEED_OUT;
   logic                  BUSY;
   logic                  DONE;
   logic [CW-1:0]         COUNT_OUT;
   modport master (
      output START, ABORT, LEN, SEED_IN, BIT_IN,
      input  LFSR_RST, LFSR_TRIG, SEED_OUT, BUSY, DONE, COUNT_OUT
   );
   modport slave (
      input  START, ABORT, LEN, SEED_IN, BIT_IN,
      output LFSR_RST, LFSR_TRIG, SEED_OUT, BUSY, DONE, COUNT_OUT
   );
endinterface

// File: rtl/stoch_stream_ctrl.sv
// stoch_stream_ctrl: seeds an LFSR bank, steps it LEN times and counts the 1s on the returned bitstream.
// Every output is a flop, so LFSR_RST/LFSR_TRIG are glitch-free strobes.
module stoch_stream_ctrl #(
   parameter int N_LFSR = 4,
   parameter int CW     = 9
) (
   input logic           CLK,
   input logic           RESET,
   stoch_stream_if.slave bus
);
   typedef enum logic [2:0] {IDLE, LOAD0, LOAD1, RUN_H, RUN_L, FIN} state_t;
   state_t               state_q;
   logic [CW-1:0]        len_q, step_q, ones_q, count_q;
   logic [CW-1:0]        step_d, ones_d;
   logic [16*N_LFSR-1:0] seed_q, seed_d;
   logic                 rst_q, trig_q, busy_q, done_q;
   // Lane k: base seed rotated left by 4k, decorrelated by a k-multiple of 16'h1D0F; zero is never allowed.
   for (genvar k = 0; k < N_LFSR; k++) begin : g_seed
      localparam int          R = (4 * k) % 16;
      localparam logic [15:0] M = 16'(32'h1D0F * k);
      logic [31:0] rot;
      logic [15:0] s;
      assign rot = {bus.SEED_IN, bus.SEED_IN} << R;
      assign s   = rot[31:16] ^ M;
      assign seed_d[16*k +: 16] = (s == 16'h0) ? 16'hACE1 : s;
   end
   assign step_d = step_q + CW'(1);
   assign ones_d = ones_q + CW'(bus.BIT_IN);
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q <= IDLE;
         len_q   <= '0;
         step_q  <= '0;
         ones_q  <= '0;
         count_q <= '0;
         seed_q  <= {N_LFSR{16'hACE1}};
         rst_q   <= 1'b0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (bus.ABORT) begin
         state_q <= IDLE;
         rst_q   <= 1'b0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (bus.START) begin
               state_q <= LOAD0;
               len_q   <= bus.LEN;
               seed_q  <= seed_d;
               step_q  <= '0;
               ones_q  <= '0;
               rst_q   <= 1'b1;
               busy_q  <= 1'b1;
            end
            LOAD0: state_q <= LOAD1;
            LOAD1: begin
               rst_q   <= 1'b0;
               state_q <= (len_q == '0) ? FIN : RUN_H;
               trig_q  <= (len_q != '0);
               done_q  <= (len_q == '0);
               if (len_q == '0) count_q <= ones_q;
            end
            RUN_H: begin
               state_q <= RUN_L;
               trig_q  <= 1'b0;
            end
            RUN_L: begin
               ones_q  <= ones_d;
               step_q  <= step_d;
               state_q <= (step_d == len_q) ? FIN : RUN_H;
               trig_q  <= (step_d != len_q);
               done_q  <= (step_d == len_q);
               if (step_d == len_q) count_q <= ones_d;
            end
            FIN: begin
               state_q <= IDLE;
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.LFSR_RST  = rst_q;
   assign bus.LFSR_TRIG = trig_q;
   assign bus.SEED_OUT  = seed_q;
   assign bus.BUSY      = busy_q;
   assign bus.DONE      = done_q;
   assign bus.COUNT_OUT = count_q;
endmodule

// File: tb/tb_stoch_stream_ctrl.sv
// tb_stoch_stream_ctrl: directed vectors for the stochastic stream sequencer.
// A reference LFSR16 fed from SEED_OUT lane0 supplies BIT_IN for the long pseudo-random run.
module tb_stoch_stream_ctrl;
   localparam int N  = 4;
   localparam int CW = 9;
   logic clk = 1'b0;
   logic rst = 1'b1;
   stoch_stream_if #(.N_LFSR(N), .CW(CW)) bus ();
   stoch_stream_ctrl #(.N_LFSR(N), .CW(CW)) dut (.CLK(clk), .RESET(rst), .bus(bus.slave));
   always #5 clk = ~clk;
   int ecnt = 0;
   int pass_cnt = 0;
   int chk_cnt = 0;
   int t0, done_cyc, trigs, rsts, exp_ones, prev_cnt, prev_done, falls;
   logic [15:0] st;
   logic pt, seen;
   always @(posedge clk) ecnt <= ecnt + 1;
   function automatic logic [15:0] lfsr_step(input logic [15:0] s);
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
   endfunction
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      chk_cnt++;
      if (got === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask
   // mode 0/1: constant BIT_IN, mode 2: reference LFSR bit; poke pulses START mid-run.
   task automatic run(input logic [CW-1:0] len, input logic [15:0] seed, input int mode, input bit poke);
      logic b;
      @(negedge clk);
      bus.START = 1'b1;
      bus.LEN = len;
      bus.SEED_IN = seed;
      @(posedge clk);
      #1;
      t0 = ecnt;
      bus.START = 1'b0;
      pt = 1'b0;
      trigs = 0;
      rsts = 0;
      exp_ones = 0;
      done_cyc = -1;
      for (int i = 0; i < 1100; i++) begin
         @(negedge clk);
         bus.START = poke && trigs == 2;
         if (poke && trigs == 2) bus.LEN = 9'd3;
         if (bus.LFSR_RST) begin
            rsts++;
            st = bus.SEED_OUT[15:0];
         end
         if (bus.LFSR_TRIG && !pt) begin
            trigs++;
            st = lfsr_step(st);
         end
         b = (mode == 2) ? st[15] : mode[0];
         bus.BIT_IN = b;
         if (!bus.LFSR_TRIG && pt) exp_ones += int'(b);
         pt = bus.LFSR_TRIG;
         if (bus.DONE) begin
            done_cyc = ecnt + 1;
            break;
         end
      end
      bus.START = 1'b0;
      check("done_seen", 32'(done_cyc != -1), 32'd1);
   endtask
   initial begin
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      bus.LEN = '0;
      bus.SEED_IN = '0;
      bus.BIT_IN = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(bus.BUSY), 32'd0);
      check("rst_done", 32'(bus.DONE), 32'd0);
      check("rst_trig", 32'(bus.LFSR_TRIG), 32'd0);
      check("rst_lrst", 32'(bus.LFSR_RST), 32'd0);
      check("rst_count", 32'(bus.COUNT_OUT), 32'd0);
      check("rst_lane0", 32'(bus.SEED_OUT[15:0]), 32'hACE1);
      check("rst_lane3", 32'(bus.SEED_OUT[63:48]), 32'hACE1);
      rst = 1'b0;
      @(negedge clk);
      bus.START = 1'b1;
      bus.ABORT = 1'b1;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      bus.ABORT = 1'b0;
      check("abort_start_busy", 32'(bus.BUSY), 32'd0);
      check("abort_start_lrst", 32'(bus.LFSR_RST), 32'd0);
      run(9'd5, 16'h1234, 1, 1'b0);
      check("l5_trigs", 32'(trigs), 32'd5);
      check("l5_rsts", 32'(rsts), 32'd2);
      check("l5_lat", 32'(done_cyc - t0), 32'd13);
      check("l5_count", 32'(bus.COUNT_OUT), 32'd5);
      check("l5_lane0", 32'(bus.SEED_OUT[15:0]), 32'h1234);
      check("l5_lane1", 32'(bus.SEED_OUT[31:16]), 32'h3E4E);
      check("l5_lane2", 32'(bus.SEED_OUT[47:32]), 32'h0E0C);
      check("l5_lane3", 32'(bus.SEED_OUT[63:48]), 32'h160E);
      @(posedge clk);
      #1;
      check("l5_busy_fall", 32'(bus.BUSY), 32'd0);
      run(9'd5, 16'h1234, 0, 1'b0);
      check("l5z_count", 32'(bus.COUNT_OUT), 32'd0);
      check("l5z_lat", 32'(done_cyc - t0), 32'd13);
      run(9'd256, 16'hBEEF, 2, 1'b0);
      check("l256_trigs", 32'(trigs), 32'd256);
      check("l256_lat", 32'(done_cyc - t0), 32'd515);
      check("l256_count", 32'(bus.COUNT_OUT), 32'(exp_ones));
      prev_cnt = exp_ones;
      @(negedge clk);
      bus.START = 1'b1;
      bus.LEN = 9'd10;
      bus.SEED_IN = 16'h5555;
      bus.BIT_IN = 1'b1;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      pt = 1'b0;
      falls = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (!bus.LFSR_TRIG && pt) falls++;
         pt = bus.LFSR_TRIG;
         if (falls == 3) break;
      end
      check("abort_reach", 32'(falls), 32'd3);
      bus.ABORT = 1'b1;
      @(posedge clk);
      #1;
      bus.ABORT = 1'b0;
      check("abort_busy", 32'(bus.BUSY), 32'd0);
      check("abort_trig", 32'(bus.LFSR_TRIG), 32'd0);
      check("abort_lrst", 32'(bus.LFSR_RST), 32'd0);
      check("abort_done", 32'(bus.DONE), 32'd0);
      check("abort_count", 32'(bus.COUNT_OUT), 32'(prev_cnt));
      seen = 1'b0;
      repeat (25) begin
         @(negedge clk);
         seen = seen | bus.DONE | bus.BUSY;
      end
      check("abort_quiet", 32'(seen), 32'd0);
      run(9'd6, 16'h0F0F, 1, 1'b1);
      check("poke_trigs", 32'(trigs), 32'd6);
      check("poke_lat", 32'(done_cyc - t0), 32'd15);
      check("poke_count", 32'(bus.COUNT_OUT), 32'd6);
      @(negedge clk);
      bus.START = 1'b1;
      bus.LEN = 9'd20;
      @(posedge clk);
      #1;
      bus.START = 1'b0;
      repeat (7) @(negedge clk);
      check("mid_busy", 32'(bus.BUSY), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("arst_busy", 32'(bus.BUSY), 32'd0);
      check("arst_trig", 32'(bus.LFSR_TRIG), 32'd0);
      check("arst_lrst", 32'(bus.LFSR_RST), 32'd0);
      check("arst_count", 32'(bus.COUNT_OUT), 32'd0);
      check("arst_lane2", 32'(bus.SEED_OUT[47:32]), 32'hACE1);
      @(negedge clk);
      rst = 1'b0;
      run(9'd0, 16'h0000, 1, 1'b0);
      check("l0_rsts", 32'(rsts), 32'd2);
      check("l0_trigs", 32'(trigs), 32'd0);
      check("l0_lat", 32'(done_cyc - t0), 32'd3);
      check("l0_count", 32'(bus.COUNT_OUT), 32'd0);
      check("z_lane0", 32'(bus.SEED_OUT[15:0]), 32'hACE1);
      check("z_lane1", 32'(bus.SEED_OUT[31:16]), 32'h1D0F);
      check("z_lane2", 32'(bus.SEED_OUT[47:32]), 32'h3A1E);
      check("z_lane3", 32'(bus.SEED_OUT[63:48]), 32'h572D);
      run(9'd511, 16'hA5A5, 1, 1'b0);
      check("l511_trigs", 32'(trigs), 32'd511);
      check("l511_lat", 32'(done_cyc - t0), 32'd1025);
      check("l511_count", 32'(bus.COUNT_OUT), 32'd511);
      prev_done = done_cyc;
      run(9'd1, 16'h0001, 1, 1'b0);
      check("b2b_accept", 32'(t0), 32'(prev_done + 1));
      check("b2b_lat", 32'(done_cyc - t0), 32'd5);
      check("b2b_count", 32'(bus.COUNT_OUT), 32'd1);
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
